// File: rtl/led_pwm_dimmer_pkg.sv
// Shared constants, types and helpers for the LED PWM dimmer output stage.
// Defaults target a 50 MHz sys_clk: 20 ms debounce, 50 kHz PWM, 8 brightness levels.
package led_pkg;

  localparam int LED_W = 4;
  localparam logic [LED_W-1:0] LED_OFF = 4'b1111;

  localparam logic [19:0] DEB_MAX_DEF    = 20'd999_999;
  localparam logic [9:0]  PWM_PERIOD_DEF = 10'd1000;
  localparam logic [9:0]  DUTY_STEP_DEF  = 10'd125;
  localparam logic [3:0]  LEVEL_MAX_DEF  = 4'd8;

  typedef logic [3:0]  level_t;
  typedef logic [9:0]  pwm_t;
  typedef logic [19:0] deb_t;

  typedef enum logic [1:0] {
    LVL_HOLD = 2'd0,
    LVL_UP   = 2'd1,
    LVL_DN   = 2'd2
  } lvl_op_e;

  // Simultaneous up and down presses cancel out.
  function automatic lvl_op_e lvl_op(input logic up, input logic dn);
    lvl_op_e op;
    op = LVL_HOLD;
    if (up && !dn) op = LVL_UP;
    if (dn && !up) op = LVL_DN;
    return op;
  endfunction

  // LEVEL_MAX*DUTY_STEP == PWM_PERIOD keeps this within 10 bits.
  function automatic pwm_t duty_of(input level_t lvl, input pwm_t step);
    return pwm_t'({6'd0, lvl} * step);
  endfunction

endpackage

// File: rtl/led_pwm_dimmer_key_filter.sv
// Key synchroniser and debouncer: emits one 1-cycle press pulse per continuous low hold.
// Pulse appears DEB_MAX+2 clk after the raw key first goes low; release is silent.
module key_filter
  import led_pkg::*;
#(
  parameter deb_t DEB_MAX = DEB_MAX_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_n,
  output logic press
);

  logic sync1_q;
  logic sync2_q;
  deb_t cnt_q;
  deb_t cnt_d;
  logic press_q;
  logic press_d;

  // Any high sample restarts the count, so bounces never reach DEB_MAX-1.
  always_comb begin
    cnt_d = cnt_q;
    if (sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != DEB_MAX) begin
      cnt_d = cnt_q + deb_t'(1);
    end
    press_d = (cnt_q == DEB_MAX - deb_t'(1));
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/led_pwm_dimmer.sv
// PWM dimmer for the active-low running-light pattern; brightness stepped by two keys.
// led_in -> led_out latency 1 clk; level changes apply from the next PWM period start.
module led_pwm_dimmer
  import led_pkg::*;
#(
  parameter deb_t   DEB_MAX    = DEB_MAX_DEF,
  parameter pwm_t   PWM_PERIOD = PWM_PERIOD_DEF,
  parameter pwm_t   DUTY_STEP  = DUTY_STEP_DEF,
  parameter level_t LEVEL_MAX  = LEVEL_MAX_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             key_up_n,
  input  logic             key_dn_n,
  input  logic [LED_W-1:0] led_in,
  output logic [LED_W-1:0] led_out,
  output logic [3:0]       level
);

  logic press_up;
  logic press_dn;

  level_t          level_q;
  level_t          level_d;
  pwm_t            pwm_cnt_q;
  pwm_t            pwm_cnt_d;
  pwm_t            duty_q;
  pwm_t            duty_d;
  logic [LED_W-1:0] led_q;
  logic [LED_W-1:0] led_d;
  logic            period_end;
  logic            pwm_on;

  key_filter #(.DEB_MAX(DEB_MAX)) u_key_up (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .key_n   (key_up_n),
    .press   (press_up)
  );

  key_filter #(.DEB_MAX(DEB_MAX)) u_key_dn (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .key_n   (key_dn_n),
    .press   (press_dn)
  );

  always_comb begin
    level_d = level_q;
    case (lvl_op(press_up, press_dn))
      LVL_UP:  if (level_q < LEVEL_MAX) level_d = level_q + level_t'(1);
      LVL_DN:  if (level_q != '0)       level_d = level_q - level_t'(1);
      default: level_d = level_q;
    endcase
  end

  // Duty is only reloaded at the period boundary so a period is never cut short.
  always_comb begin
    period_end = (pwm_cnt_q == PWM_PERIOD - pwm_t'(1));
    pwm_cnt_d  = period_end ? '0 : pwm_cnt_q + pwm_t'(1);
    duty_d     = period_end ? duty_of(level_q, DUTY_STEP) : duty_q;
    pwm_on     = (pwm_cnt_q < duty_q);
    led_d      = pwm_on ? led_in : LED_OFF;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      level_q   <= LEVEL_MAX;
      duty_q    <= PWM_PERIOD;
      pwm_cnt_q <= '0;
      led_q     <= LED_OFF;
    end else begin
      level_q   <= level_d;
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
    end
  end

  assign led_out = led_q;
  assign level   = level_q;

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// Directed bench for led_pwm_dimmer with a cycle-level behavioural model and literal checkpoints.
module tb_led_pwm_dimmer;

  localparam int DEB   = 9;
  localparam int PER   = 8;
  localparam int STEP  = 2;
  localparam int LMAX  = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       key_up_n;
  logic       key_dn_n;
  logic [3:0] led_in;
  logic [3:0] led_out;
  logic [3:0] level;

  int total = 0;
  int bad   = 0;

  led_pwm_dimmer #(
    .DEB_MAX   (20'd9),
    .PWM_PERIOD(10'd8),
    .DUTY_STEP (10'd2),
    .LEVEL_MAX (4'd4)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .key_up_n(key_up_n),
    .key_dn_n(key_dn_n),
    .led_in  (led_in),
    .led_out (led_out),
    .level   (level)
  );

  always #5 sys_clk = ~sys_clk;

  // Model: a press lands on level 4 edges after the raw key's low run reaches DEB-1 samples
  // (2 sync stages, count, press flop); PWM period duty is latched from level at period end.
  int   m_level, m_duty, m_cnt, run_up, run_dn;
  bit   dly_up[4];
  bit   dly_dn[4];
  bit   ap_up, ap_dn;
  logic [3:0] exp_led;
  bit   chk_en = 1'b0;

  always @(posedge sys_clk) begin
    if (sys_rst) begin
      m_level = LMAX;
      m_duty  = PER;
      m_cnt   = 0;
      run_up  = 0;
      run_dn  = 0;
      for (int i = 0; i < 4; i++) begin
        dly_up[i] = 1'b0;
        dly_dn[i] = 1'b0;
      end
      exp_led = 4'b1111;
      chk_en  = 1'b1;
    end else begin
      ap_up = dly_up[3];
      ap_dn = dly_dn[3];
      for (int i = 3; i > 0; i--) begin
        dly_up[i] = dly_up[i-1];
        dly_dn[i] = dly_dn[i-1];
      end
      run_up = key_up_n ? 0 : run_up + 1;
      run_dn = key_dn_n ? 0 : run_dn + 1;
      dly_up[0] = (run_up == DEB - 1);
      dly_dn[0] = (run_dn == DEB - 1);
      exp_led = (m_cnt < m_duty) ? led_in : 4'b1111;
      if (m_cnt == PER - 1) m_duty = m_level * STEP;
      m_cnt = (m_cnt + 1) % PER;
      if (ap_up && !ap_dn && m_level < LMAX) m_level = m_level + 1;
      else if (ap_dn && !ap_up && m_level > 0) m_level = m_level - 1;
    end
  end

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge sys_clk) begin
    if (chk_en) begin
      check4("model_led_out", led_out, exp_led);
      check4("model_level", level, 4'(m_level));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wait_cnt(input int target);
    int k;
    k = 0;
    while (m_cnt != target && k < 2 * PER) begin
      @(negedge sys_clk);
      k++;
    end
    if (m_cnt != target) begin
      total++;
      bad++;
      $display("FAIL wait_cnt: phase %0d not reached, at %0d", target, m_cnt);
    end
  endtask

  // Count lit cycles over one whole PWM period as seen at led_out (led_in held 1110).
  task automatic measure(output int on);
    on = 0;
    wait_cnt(1);
    for (int i = 0; i < PER; i++) begin
      if (led_out == 4'b1110) on++;
      @(negedge sys_clk);
    end
  endtask

  task automatic press(input bit up);
    if (up) key_up_n = 1'b0; else key_dn_n = 1'b0;
    idle(20);
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    idle(15);
  endtask

  logic [3:0] pats [6];
  int on;

  initial begin
    pats[0] = 4'b1110; pats[1] = 4'b1101; pats[2] = 4'b1011;
    pats[3] = 4'b0111; pats[4] = 4'b0000; pats[5] = 4'b1010;

    sys_rst  = 1'b1;
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    led_in   = 4'b1110;

    // 1. reset, full duty
    idle(3);
    check4("rst_led_out", led_out, 4'b1111);
    check4("rst_level", level, 4'd4);
    sys_rst = 1'b0;
    idle(1);
    check4("release_led_out", led_out, 4'b1110);
    measure(on);
    check_int("full_duty_on", on, 8);

    // pass-through of arbitrary patterns at full brightness
    for (int i = 0; i < 6; i++) begin
      led_in = pats[i];
      idle(1);
      check4("passthru", led_out, pats[i]);
    end
    led_in = 4'b1110;
    idle(2);

    // 2. single press
    press(1'b0);
    check4("single_dn_level", level, 4'd3);
    measure(on);
    check_int("level3_on", on, 6);

    // 3. bounce rejection
    repeat (6) begin
      key_up_n = 1'b0;
      idle(5);
      key_up_n = 1'b1;
      idle(1);
    end
    idle(15);
    check4("bounce_level", level, 4'd3);

    // 4. saturation
    repeat (5) press(1'b0);
    check4("sat_low_level", level, 4'd0);
    measure(on);
    check_int("level0_on", on, 0);
    repeat (6) press(1'b1);
    check4("sat_high_level", level, 4'd4);
    measure(on);
    check_int("level4_on", on, 8);

    // 5. simultaneous presses cancel; mid-period press leaves current duty intact
    key_up_n = 1'b0;
    key_dn_n = 1'b0;
    idle(20);
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    idle(15);
    check4("both_level", level, 4'd4);
    wait_cnt(0);
    key_dn_n = 1'b0;
    measure(on);
    check_int("mid_p1_on", on, 8);
    measure(on);
    check_int("mid_p2_on", on, 8);
    measure(on);
    check_int("mid_p3_on", on, 6);
    key_dn_n = 1'b1;
    idle(15);
    check4("mid_level", level, 4'd3);

    // 6. reset mid-operation
    press(1'b0);
    press(1'b0);
    check4("pre_rst_level", level, 4'd1);
    wait_cnt(1);
    key_dn_n = 1'b0;
    idle(4);
    check_int("pre_rst_phase", m_cnt, 5);
    sys_rst  = 1'b1;
    key_dn_n = 1'b1;
    idle(1);
    check4("midrst_level", level, 4'd4);
    check4("midrst_led_out", led_out, 4'b1111);
    sys_rst = 1'b0;
    idle(1);
    check4("midrst_release_led", led_out, 4'b1110);
    idle(30);
    check4("midrst_no_press", level, 4'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
